// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per functional unit, round-robin grant,
// registered broadcast port. ROB tag 0 is reserved and never buffered or broadcast.
module cdb_arbiter #(
   parameter int unsigned NUM_FU     = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [NUM_FU-1:0]              fu_valid,
   input  logic [NUM_FU*TAG_WIDTH-1:0]    fu_tag,
   input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_data,
   output logic [NUM_FU-1:0]              fu_ready,
   output logic                           cdb_valid,
   output logic [TAG_WIDTH-1:0]           cdb_tag,
   output logic [DATA_WIDTH-1:0]          cdb_data,
   output logic [$clog2(NUM_FU)-1:0]      cdb_src
);

   localparam int unsigned SrcW = $clog2(NUM_FU);

   logic [NUM_FU-1:0]                  hold_valid_q, hold_valid_d;
   logic [NUM_FU-1:0][TAG_WIDTH-1:0]   hold_tag_q, hold_tag_d;
   logic [NUM_FU-1:0][DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
   logic [SrcW-1:0]                    rr_ptr_q, rr_ptr_d;
   logic                               cdb_valid_q, cdb_valid_d;
   logic [TAG_WIDTH-1:0]               cdb_tag_q, cdb_tag_d;
   logic [DATA_WIDTH-1:0]              cdb_data_q, cdb_data_d;
   logic [SrcW-1:0]                    cdb_src_q, cdb_src_d;

   logic [NUM_FU-1:0]                  gnt;
   logic                               gnt_any;
   logic [SrcW-1:0]                    gnt_idx;
   logic [NUM_FU-1:0]                  accept;

   // Round-robin grant from registered state only: first valid entry starting at rr_ptr.
   always_comb begin
      int unsigned idx;
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
         idx = (32'(rr_ptr_q) + k) % NUM_FU;
         if (!gnt_any && hold_valid_q[SrcW'(idx)]) begin
            gnt_any = 1'b1;
            gnt_idx = SrcW'(idx);
         end
      end
      if (gnt_any) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   // A slot can take a new result when empty or when it is being drained this cycle.
   always_comb begin
      fu_ready = ~hold_valid_q | gnt;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         accept[i] = fu_valid[i] & fu_ready[i] & (fu_tag[i*TAG_WIDTH +: TAG_WIDTH] != '0);
      end
   end

   // Next-state: flush drops everything, otherwise drain the granted slot and load accepts.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_tag_d   = hold_tag_q;
      hold_data_d  = hold_data_q;
      rr_ptr_d     = rr_ptr_q;
      cdb_valid_d  = 1'b0;
      cdb_tag_d    = '0;
      cdb_data_d   = '0;
      cdb_src_d    = cdb_src_q;
      if (flush) begin
         hold_valid_d = '0;
      end else begin
         hold_valid_d = hold_valid_q & ~gnt;
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            // A same-edge accept on the granted slot overwrites it and keeps it valid.
            if (accept[i]) begin
               hold_valid_d[i] = 1'b1;
               hold_tag_d[i]   = fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
               hold_data_d[i]  = fu_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         if (gnt_any) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = hold_tag_q[gnt_idx];
            cdb_data_d  = hold_data_q[gnt_idx];
            cdb_src_d   = gnt_idx;
            rr_ptr_d    = (gnt_idx == SrcW'(NUM_FU - 1)) ? '0 : gnt_idx + SrcW'(1);
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid_q <= '0;
         hold_tag_q   <= '0;
         hold_data_q  <= '0;
         rr_ptr_q     <= '0;
         cdb_valid_q  <= 1'b0;
         cdb_tag_q    <= '0;
         cdb_data_q   <= '0;
         cdb_src_q    <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_tag_q   <= hold_tag_d;
         hold_data_q  <= hold_data_d;
         rr_ptr_q     <= rr_ptr_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_tag_q    <= cdb_tag_d;
         cdb_data_q   <= cdb_data_d;
         cdb_src_q    <= cdb_src_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table of per-cycle stimulus and expected outputs,
// plus hand-written reset sequences.
module tb_cdb_arbiter;

   localparam int unsigned NFU = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned TW  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic [NFU-1:0]    fu_valid;
   logic [NFU*TW-1:0] fu_tag;
   logic [NFU*DW-1:0] fu_data;
   logic [NFU-1:0]    fu_ready;
   logic              cdb_valid;
   logic [TW-1:0]     cdb_tag;
   logic [DW-1:0]     cdb_data;
   logic [1:0]        cdb_src;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(
      .NUM_FU    (NFU),
      .DATA_WIDTH(DW),
      .TAG_WIDTH (TW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .fu_valid (fu_valid),
      .fu_tag   (fu_tag),
      .fu_data  (fu_data),
      .fu_ready (fu_ready),
      .cdb_valid(cdb_valid),
      .cdb_tag  (cdb_tag),
      .cdb_data (cdb_data),
      .cdb_src  (cdb_src)
   );

   typedef struct {
      logic              flush;
      logic [NFU-1:0]    valid;
      logic [NFU*TW-1:0] tags;
      logic [NFU*DW-1:0] data;
      logic              e_valid;
      logic [TW-1:0]     e_tag;
      logic [DW-1:0]     e_data;
      logic [1:0]        e_src;
      logic [NFU-1:0]    e_ready;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic fl, input logic [3:0] val, input logic [15:0] tg,
                               input logic [127:0] dt, input logic ev, input logic [3:0] et,
                               input logic [31:0] ed, input logic [1:0] es,
                               input logic [3:0] er);
      vec_t v;
      v.flush = fl; v.valid = val; v.tags = tg; v.data = dt;
      v.e_valid = ev; v.e_tag = et; v.e_data = ed; v.e_src = es; v.e_ready = er;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_outputs(input int idx, input logic ev, input logic [3:0] et,
                                input logic [31:0] ed, input logic [1:0] es,
                                input logic [3:0] er);
      chk("cdb_valid", idx, 32'(cdb_valid), 32'(ev));
      chk("cdb_tag",   idx, 32'(cdb_tag),   32'(et));
      chk("cdb_data",  idx, cdb_data,       ed);
      chk("cdb_src",   idx, 32'(cdb_src),   32'(es));
      chk("fu_ready",  idx, 32'(fu_ready),  32'(er));
   endtask

   task automatic idle_inputs();
      flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_data = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();

      // Reset held two cycles with every FU presenting a result.
      fu_valid = 4'b1111;
      fu_tag   = {4'd4, 4'd3, 4'd2, 4'd1};
      fu_data  = {32'd4, 32'd3, 32'd2, 32'd1};
      repeat (2) @(posedge clk);
      #1;
      check_outputs(-1, 1'b0, 4'd0, 32'd0, 2'd0, 4'b1111);
      rst = 1'b0;
      idle_inputs();

      // Single result, FU0 tag 3.
      vecs.push_back(mk(0, 4'b0001, 16'h0003, {96'd0, 32'd101}, 0, 0, 0, 0, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 3, 101, 0, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 0, 0, 0, 0, 4'b1111));
      // FU3 alone so the pointer wraps back to 0.
      vecs.push_back(mk(0, 4'b1000, 16'h8000, {32'd80, 96'd0}, 0, 0, 0, 0, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 8, 80, 3, 4'b1111));
      // Contention: all four in one cycle, drained 1,2,3,4.
      vecs.push_back(mk(0, 4'b1111, 16'h4321, {32'd44, 32'd33, 32'd22, 32'd11},
                        0, 0, 0, 3, 4'b0001));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 1, 11, 0, 4'b0011));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 2, 22, 1, 4'b0111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 3, 33, 2, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 4, 44, 3, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 0, 0, 0, 3, 4'b1111));
      // Fairness: FU1 and FU3 keep offering new tags; grants alternate.
      vecs.push_back(mk(0, 4'b1010, 16'h9050, {32'd903, 32'd0, 32'd501, 32'd0},
                        0, 0, 0, 3, 4'b0111));
      vecs.push_back(mk(0, 4'b1010, 16'hA060, {32'd1003, 32'd0, 32'd601, 32'd0},
                        1, 5, 501, 1, 4'b1101));
      vecs.push_back(mk(0, 4'b1010, 16'hB070, {32'd1103, 32'd0, 32'd701, 32'd0},
                        1, 9, 903, 3, 4'b0111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 6, 601, 1, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 11, 1103, 3, 4'b1111));
      // Tag 0 is dropped; then back-to-back uncontended tags 5,6 from FU2.
      vecs.push_back(mk(0, 4'b0100, 16'h0000, {32'd0, 32'd55, 64'd0}, 0, 0, 0, 3, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 0, 0, 0, 3, 4'b1111));
      vecs.push_back(mk(0, 4'b0100, 16'h0500, {32'd0, 32'd50, 64'd0}, 0, 0, 0, 3, 4'b1111));
      vecs.push_back(mk(0, 4'b0100, 16'h0600, {32'd0, 32'd60, 64'd0}, 1, 5, 50, 2, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 6, 60, 2, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 0, 0, 0, 2, 4'b1111));
      // Flush with FU0..2 pending: nothing is broadcast, then a fresh result flows normally.
      vecs.push_back(mk(0, 4'b0111, 16'h0321, {32'd0, 32'd9, 32'd8, 32'd7},
                        0, 0, 0, 2, 4'b1001));
      vecs.push_back(mk(1, 4'b0000, 16'h0000, 128'd0, 0, 0, 0, 2, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 0, 0, 0, 2, 4'b1111));
      vecs.push_back(mk(0, 4'b0010, 16'h0070, {64'd0, 32'd9, 32'd0}, 0, 0, 0, 2, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 1, 7, 9, 1, 4'b1111));
      // Flush blocks an accept in the same cycle.
      vecs.push_back(mk(1, 4'b0001, 16'h000C, {96'd0, 32'd120}, 0, 0, 0, 1, 4'b1111));
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 128'd0, 0, 0, 0, 1, 4'b1111));

      foreach (vecs[i]) begin
         flush    = vecs[i].flush;
         fu_valid = vecs[i].valid;
         fu_tag   = vecs[i].tags;
         fu_data  = vecs[i].data;
         @(posedge clk);
         #1;
         check_outputs(i, vecs[i].e_valid, vecs[i].e_tag, vecs[i].e_data, vecs[i].e_src,
                       vecs[i].e_ready);
      end

      // Reset with a result pending discards it and clears cdb_src.
      fu_valid = 4'b0100;
      fu_tag   = 16'h0400;
      fu_data  = {32'd0, 32'd77, 64'd0};
      @(posedge clk);
      #1;
      chk("pend_ready", 100, 32'(fu_ready), 32'(4'b1111));
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_outputs(101, 1'b0, 4'd0, 32'd0, 2'd0, 4'b1111);
      @(posedge clk);
      #1;
      check_outputs(102, 1'b0, 4'd0, 32'd0, 2'd0, 4'b1111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
